// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule datapath.
// Holds the word type, schedule length, small-sigma rotate/shift amounts and FSM encoding.
package sha256_pkg;

    localparam int WORD_BITS  = 32;
    localparam int NUM_ROUNDS = 64;

    typedef logic [WORD_BITS-1:0] word_t;

    localparam int S0_R1 = 7;
    localparam int S0_R2 = 18;
    localparam int S0_SH = 3;
    localparam int S1_R1 = 17;
    localparam int S1_R2 = 19;
    localparam int S1_SH = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_BITS - n));
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Small sigma function: SEL=0 gives s0, SEL=1 gives s1.
// Latency: combinational. Backpressure: none (pure function).
// Rotate/shift amounts come from the package so both sigmas share one body.
module sha256_small_sigma #(
    parameter bit SEL = 1'b0
) (
    input  logic [31:0] x,
    output logic [31:0] y
);
    import sha256_pkg::*;

    localparam int R1 = SEL ? S1_R1 : S0_R1;
    localparam int R2 = SEL ? S1_R2 : S0_R2;
    localparam int SH = SEL ? S1_SH : S0_SH;

    assign y = rotr(x, R1) ^ rotr(x, R2) ^ (x >> SH);

endmodule

// File: rtl/sha256_w_sched.sv
// SHA-256 message schedule: loads one 512-bit block, emits W[0..63] one word per cycle.
// Latency: W[0] one cycle after start is taken, W[63] 63 cycles later, done the cycle after.
// Backpressure: hold freezes window, index and outputs while running; start is taken only when ready.
module sha256_w_sched #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [511:0]      blk_in,
    input  logic              hold,
    output logic              ready,
    output logic              w_valid,
    output logic [WORD_W-1:0] w_out,
    output logic [IDX_W-1:0]  w_idx,
    output logic              done
);
    import sha256_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    word_t            w [16];
    logic [IDX_W-1:0] idx_q;
    logic             load, adv;
    word_t            s0_y, s1_y, w_new;

    sha256_small_sigma #(.SEL(1'b0)) u_s0 (.x(w[1]),  .y(s0_y));
    sha256_small_sigma #(.SEL(1'b1)) u_s1 (.x(w[14]), .y(s1_y));

    // Window position 15 receives W[t+16] while position 0 holds W[t].
    assign w_new = s1_y + w[9] + s0_y + w[0];

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!hold) begin
                    if (idx_q == LAST_IDX) state_d = ST_DONE;
                    else                   adv     = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                idx_q <= '0;
                for (int i = 0; i < 16; i++) w[i] <= blk_in[511-32*i -: 32];
            end else if (adv) begin
                idx_q <= idx_q + 1'b1;
                for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
            end
        end
    end

    // All outputs decode registered state only.
    assign ready   = (state_q == ST_IDLE);
    assign w_valid = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign w_out   = w[0];
    assign w_idx   = idx_q;

endmodule

// File: tb/tb_sha256_w_sched.sv
module tb_sha256_w_sched;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] blk_in;
    logic         hold;
    logic         ready;
    logic         w_valid;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_w [64];

    localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] ZERO_BLK = 512'd0;
    localparam logic [511:0] ALT_BLK  = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'h00000001,
                                         32'h80000000, 32'h12345678, 32'hffffffff, 32'h0f0f0f0f,
                                         32'hf0f0f0f0, 32'h55555555, 32'haaaaaaaa, 32'h13579bdf,
                                         32'h2468ace0, 32'h00ff00ff, 32'hcafef00d, 32'h00000200};

    sha256_w_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .blk_in  (blk_in),
        .hold    (hold),
        .ready   (ready),
        .w_valid (w_valid),
        .w_out   (w_out),
        .w_idx   (w_idx),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule in the textbook form W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
    task automatic gen_exp(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511-32*i -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
    endtask

    task automatic run_block(input string name, input logic [511:0] blk, input logic [511:0] nxt,
                             input bit is_abc, input int stall_len, input bit keep_start);
        int k;
        int cyc;
        int stalled;
        gen_exp(blk);
        blk_in = blk;
        start  = 1'b1;
        hold   = 1'b0;
        step();
        cyc = 1;
        if (keep_start) blk_in = nxt;
        else            start  = 1'b0;
        k = 0;
        stalled = 0;
        while (k < 64 && cyc < 200) begin
            check($sformatf("%s_vld_%0d", name, k), w_valid, 1'b1);
            check($sformatf("%s_idx_%0d", name, k), w_idx, k);
            check($sformatf("%s_w_%0d", name, k), w_out, exp_w[k]);
            check($sformatf("%s_rdy_%0d", name, k), ready, 1'b0);
            if (is_abc && k == 16) check($sformatf("%s_w16", name), w_out, 32'h61626380);
            if (is_abc && k == 17) check($sformatf("%s_w17", name), w_out, 32'h000F0000);
            if (is_abc && k == 63) check($sformatf("%s_w63", name), w_out, 32'h12B1EDEB);
            if (k == 20 && stalled < stall_len) begin
                hold = 1'b1;
                stalled++;
            end else begin
                hold = 1'b0;
                k++;
            end
            step();
            cyc++;
        end
        check($sformatf("%s_done_cycle", name), cyc, 65 + stall_len);
        check($sformatf("%s_done", name), done, 1'b1);
        check($sformatf("%s_done_vld", name), w_valid, 1'b0);
        check($sformatf("%s_done_rdy", name), ready, 1'b0);
        step();
        check($sformatf("%s_idle_rdy", name), ready, 1'b1);
        check($sformatf("%s_idle_done", name), done, 1'b0);
        check($sformatf("%s_idle_vld", name), w_valid, 1'b0);
        if (keep_start) begin
            step();
            gen_exp(nxt);
            check($sformatf("%s_next_vld", name), w_valid, 1'b1);
            check($sformatf("%s_next_idx", name), w_idx, 0);
            check($sformatf("%s_next_w0", name), w_out, exp_w[0]);
        end
    endtask

    initial begin
        int done_cnt;
        rst_n  = 1'b0;
        start  = 1'b0;
        hold   = 1'b0;
        blk_in = '0;
        step();
        step();
        check("rst_ready", ready, 1'b1);
        check("rst_vld", w_valid, 1'b0);
        check("rst_idx", w_idx, 0);
        check("rst_done", done, 1'b0);
        rst_n = 1'b1;
        step();

        run_block("abc", ABC_BLK, ZERO_BLK, 1'b1, 0, 1'b0);
        run_block("zero", ZERO_BLK, ZERO_BLK, 1'b0, 0, 1'b0);
        run_block("stall", ABC_BLK, ZERO_BLK, 1'b1, 3, 1'b0);
        run_block("keep", ABC_BLK, ALT_BLK, 1'b1, 0, 1'b1);

        // Second block is now running; advance to index 10 and reset mid-block.
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("alt_idx_%0d", i), w_idx, i);
            check($sformatf("alt_w_%0d", i), w_out, exp_w[i]);
        end
        rst_n = 1'b0;
        #1;
        check("arst_vld", w_valid, 1'b0);
        check("arst_idx", w_idx, 0);
        check("arst_ready", ready, 1'b1);
        check("arst_done", done, 1'b0);
        step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("arst_no_done", done_cnt, 0);
        check("arst_idle_ready", ready, 1'b1);

        // hold raised together with start in IDLE must not block the load.
        blk_in = ABC_BLK;
        start  = 1'b1;
        hold   = 1'b1;
        step();
        start = 1'b0;
        check("idlehold_vld", w_valid, 1'b1);
        check("idlehold_idx0", w_idx, 0);
        check("idlehold_w0", w_out, 32'h61626380);
        step();
        check("idlehold_stall_idx", w_idx, 0);
        check("idlehold_stall_w", w_out, 32'h61626380);
        hold = 1'b0;
        step();
        check("idlehold_idx1", w_idx, 1);
        check("idlehold_w1", w_out, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_w_sched.md
Name: sha256_w_sched

Overview:
- Sequences the SHA-256 message-schedule datapath: accepts one 512-bit block and emits W[0..63], one word per cycle, to the compression round logic.
- Holds a 16-word sliding window. Each step computes W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], modulo 2^32.
- Sits between the block/nonce assembler and the round core.
- Provides a start/ready/done handshake and a consumer stall input.

Parameters:
- WORD_W, 32: word width; only 32 is supported.
- ROUNDS, 64: number of W words emitted per block.
- IDX_W, 6: width of w_idx, equal to clog2(ROUNDS).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request to load blk_in; sampled only when ready=1.
- blk_in, input, 512: message block; W[0]=blk_in[511:480] through W[15]=blk_in[31:0].
- hold, input, 1: consumer stall; freezes the window and outputs while RUN.
- ready, output, 1: high in IDLE; block can be accepted.
- w_valid, output, 1: w_out/w_idx hold a valid schedule word.
- w_out, output, 32: current schedule word W[w_idx].
- w_idx, output, 6: index t of w_out.
- done, output, 1: one-cycle pulse after W[63] is consumed.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, window regs=0, w_idx=0, w_valid=0, done=0, ready=1. Takes effect mid-block; the partial block is discarded and no done pulse occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1, w_valid=0.
  - On a clk edge with start=1: load window w[0..15] from blk_in, set w_idx=0, go to RUN.
  - hold is ignored in IDLE.
- RUN:
  - w_valid=1, w_out=w[0] (register output, no combinational path from inputs), ready=0.
  - On an edge with hold=0 and w_idx<63: shift w[i]<=w[i+1] for i=0..14, set w[15]<=s1(w[14])+w[9]+s0(w[1])+w[0] (mod 2^32), w_idx<=w_idx+1.
  - On an edge with hold=0 and w_idx==63: go to DONE, w_valid<=0.
  - On an edge with hold=1: all registers unchanged.
  - start is ignored in RUN and DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ready=0 during DONE.
- Latency:
  - start edge at cycle N gives W[0] visible in cycle N+1.
  - With no hold, W[63] appears in cycle N+64 and done in cycle N+65.
  - ready returns in cycle N+66.
- Minimum block-to-block interval: 66 cycles.
- Sigma functions:
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- The adder chain is combinational within one cycle, with 4-operand modular addition and carries discarded.
- Words 49..63 of the window feed values that are never emitted. They are still computed; no special-casing.

Decomposition:
- Package sha256_pkg:
  - word type (32 bits).
  - ROUNDS.
  - Rotate/shift constants for s0 (7, 18, 3) and s1 (17, 19, 10).
  - State encoding for IDLE/RUN/DONE.
- Sub-module sha256_small_sigma:
  - Combinational; parameter SEL (0 selects s0, 1 selects s1); ports x in, y out.
  - Instantiated twice in this block.

Test Plan:
- Reset: drive rst_n=0 mid-RUN at w_idx=10 -> w_valid=0, w_idx=0, ready=1, done=0 immediately (async); no done pulse afterwards.
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), hold=0 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; W[0] one cycle after start; done pulses exactly one cycle after the W63 cycle.
- All-zero block -> all 64 w_out=0x00000000, w_idx steps 0..63 with no gaps; 64 consecutive w_valid cycles.
- Stall: "abc" block, hold=1 for 3 cycles while w_idx=20 -> w_out and w_idx stay at 20 for 4 cycles total; subsequent words match the no-stall sequence; done is delayed by exactly 3 cycles.
- start=1 held continuously from IDLE through RUN with a different blk_in -> second block is not loaded until ready=1 again; the first block's 64 words are unaffected; the second block starts the cycle after ready returns.
- hold=1 asserted in IDLE together with start -> block loads and W[0] appears next cycle; hold only takes effect once RUN is entered.
